mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 clk  in  1  single system clock, all state on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 req  in  1  pipeline MEM stage holds a load/store this cycle.
REQ-004 memOp  in  3  000 LB, 001 LH, 010 LW, 011 SB, 100 LBU, 101 LHU, 110 SH, 111 SW.
REQ-005 address  in  32  byte address from ALU.
REQ-006 storeData  in  32  register value to store; low byte/halfword used for SB/SH.
REQ-007 cacheStop  in  1  cache stall output; 1 = current cache request not completed this cycle.
REQ-008 cacheData  in  32  word read from cache, valid when cacheReadMem=1 and cacheStop=0.
REQ-009 cacheAddress  out  32  word address to cache, always {addr[31:2],2'b00}.
REQ-010 cacheWriteData  out  32  full word to write.
REQ-011 cacheReadMem / cacheWriteMem  out  1 each  cache read/write strobes, never both high.
REQ-012 loadData  out  32  extended load result, valid only in the completion cycle of a load.
REQ-013 stall  out  1  1 = pipeline must hold MEM stage.
REQ-014 alignErr  out  1  misaligned-access flag, combinational.

Function
REQ-015 FSM states IDLE, ACCESS, RMW_READ, RMW_WRITE; exactly one cache strobe per non-IDLE state, none in IDLE.
REQ-016 Misaligned: LW/SW with addr[1:0]!=0, LH/LHU/SH with addr[0]!=0; in IDLE with req this sets alignErr=1, stall=0, no cache access, state stays IDLE.
REQ-017 IDLE, req=1, aligned: latch memOp, address, storeData; stall=1; next state ACCESS for loads/SW, RMW_READ for SB/SH.
REQ-018 ACCESS: cacheReadMem=1 (load) or cacheWriteMem=1 with latched storeData (SW); while cacheStop=1 remain, stall=1.
REQ-019 ACCESS with cacheStop=0: completion cycle; stall=0; for loads loadData = extended cacheData this cycle; next state IDLE.
REQ-020 RMW_READ: cacheReadMem=1; when cacheStop=0 register merged word (cacheData with target byte/halfword replaced by storeData low bits) and go RMW_WRITE; stall=1 throughout.
REQ-021 RMW_WRITE: cacheWriteMem=1, cacheWriteData=merged word; cacheStop=0 is completion cycle (stall=0), next IDLE.
REQ-022 Little-endian: byte k = bits [8k+7:8k], k=addr[1:0]; halfword h = bits [16h+15:16h], h=addr[1].
REQ-023 LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes word unchanged.
REQ-024 Minimum latency: 2 cycles for loads/SW (accept + access), 3 for SB/SH; each cacheStop cycle adds one.
REQ-025 req ignored outside IDLE; latched operands only change in IDLE on acceptance.
REQ-026 In the completion cycle the pipeline advances; a req seen in the following IDLE cycle is a new instruction.
REQ-027 loadData = 0 in every non-completion cycle.

Reset
REQ-028 rst=0 forces IDLE immediately, including mid-access; strobes, stall, alignErr, loadData drop to 0 asynchronously.
REQ-029 Latched address/data/merge registers reset to 0; first accept allowed on first clock edge after rst=1.

Structure
REQ-030 memOp encodings and state encodings in shared package mem_pkg.
REQ-031 One combinational sub-module mem_align (byte/halfword extract-extend and store merge); FSM in mem_access_unit.

Verification
REQ-032 LW 0x100, cacheData=0xDEADBEEF, cacheStop=0 -> stall 1 cycle, then loadData=0xDEADBEEF, stall=0.
REQ-033 LB 0x103, word 0x80112233 -> loadData=0xFFFFFF80; LBU same -> 0x00000080; LHU 0x102 -> 0x00008011.
REQ-034 SB 0x101 data 0xAB, existing word 0x11223344 -> RMW_WRITE writes 0x1122AB44 to 0x100, 3 cycles total.
REQ-035 LW 0x200 with cacheStop high 9 cycles (miss fill) -> cacheReadMem held 9 cycles, completion on cycle 11, stall low only then.
REQ-036 LH 0x101 -> alignErr=1, stall=0, no strobe; SW 0x202 -> same.
REQ-037 rst low during RMW_READ of SH 0x300 -> strobes low immediately, no write issued, IDLE after release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit.
// Holds the memOp encodings, FSM state encoding and small decode helpers
// used by both the FSM and the alignment datapath.
package mem_pkg;

  typedef enum logic [2:0] {
    OpLb  = 3'b000,
    OpLh  = 3'b001,
    OpLw  = 3'b010,
    OpSb  = 3'b011,
    OpLbu = 3'b100,
    OpLhu = 3'b101,
    OpSh  = 3'b110,
    OpSw  = 3'b111
  } mem_op_e;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StAccess   = 2'b01,
    StRmwRead  = 2'b10,
    StRmwWrite = 2'b11
  } state_e;

  function automatic logic is_load(mem_op_e op);
    return op inside {OpLb, OpLh, OpLw, OpLbu, OpLhu};
  endfunction

  // Sub-word stores go through a read-modify-write of the containing word.
  function automatic logic is_rmw(mem_op_e op);
    return (op == OpSb) || (op == OpSh);
  endfunction

  function automatic logic is_misaligned(mem_op_e op, logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (op)
      OpLw, OpSw:        mis = (off != 2'b00);
      OpLh, OpLhu, OpSh: mis = off[0];
      default:           mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte/halfword datapath for the memory access unit.
// Ports:
//   i_memOp     - latched memory operation
//   i_offset    - byte offset within the word (address[1:0])
//   i_word      - word read from the cache
//   i_storeData - low halfword of the store operand
//   o_loadData  - extracted and sign/zero-extended load result
//   o_mergeData - cache word with the store byte/halfword replaced
module mem_align
  import mem_pkg::*;
(
  input  mem_op_e     i_memOp,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_word,
  input  logic [15:0] i_storeData,
  output logic [31:0] o_loadData,
  output logic [31:0] o_mergeData
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Little-endian lanes: byte k at bits [8k+7:8k], halfword h at [16h+15:16h].
  assign w_byte = i_word[{i_offset, 3'b000} +: 8];
  assign w_half = i_word[{i_offset[1], 4'b0000} +: 16];

  always_comb begin
    o_loadData = i_word;
    case (i_memOp)
      OpLb:    o_loadData = {{24{w_byte[7]}}, w_byte};
      OpLh:    o_loadData = {{16{w_half[15]}}, w_half};
      OpLbu:   o_loadData = {24'h0, w_byte};
      OpLhu:   o_loadData = {16'h0, w_half};
      default: o_loadData = i_word;
    endcase
  end

  always_comb begin
    o_mergeData = i_word;
    if (i_memOp == OpSh) begin
      o_mergeData[{i_offset[1], 4'b0000} +: 16] = i_storeData;
    end else begin
      o_mergeData[{i_offset, 3'b000} +: 8] = i_storeData[7:0];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage memory access unit: drives a word-addressed cache for
// byte/halfword/word loads and stores, using read-modify-write for SB/SH.
// Ports:
//   i_clk, i_rst_n       - clock, asynchronous active-low reset
//   i_req                - MEM stage holds a load/store
//   i_memOp              - operation encoding (mem_pkg::mem_op_e)
//   i_address            - byte address
//   i_storeData          - store operand
//   i_cacheStop          - cache has not completed the current request
//   i_cacheData          - word read from the cache
//   o_cacheAddress       - word-aligned cache address
//   o_cacheWriteData     - word to write
//   o_cacheReadMem/WriteMem - cache strobes
//   o_loadData           - extended load result, nonzero only on load completion
//   o_stall              - pipeline must hold the MEM stage
//   o_alignErr           - misaligned request flag
module mem_access_unit
  import mem_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic [2:0]  i_memOp,
  input  logic [31:0] i_address,
  input  logic [31:0] i_storeData,
  input  logic        i_cacheStop,
  input  logic [31:0] i_cacheData,
  output logic [31:0] o_cacheAddress,
  output logic [31:0] o_cacheWriteData,
  output logic        o_cacheReadMem,
  output logic        o_cacheWriteMem,
  output logic [31:0] o_loadData,
  output logic        o_stall,
  output logic        o_alignErr
);

  state_e      r_state, w_state_next;
  mem_op_e     r_op;
  logic [31:0] r_addr, r_sdata, r_merge;
  mem_op_e     w_op_in;
  logic        w_misaligned, w_accept;
  logic [31:0] w_load_ext, w_merge;

  assign w_op_in      = mem_op_e'(i_memOp);
  assign w_misaligned = is_misaligned(w_op_in, i_address[1:0]);
  assign w_accept     = (r_state == StIdle) && i_req && !w_misaligned;

  assign o_cacheAddress = (r_state == StIdle) ? {i_address[31:2], 2'b00}
                                              : {r_addr[31:2], 2'b00};

  mem_align u_align (
    .i_memOp     (r_op),
    .i_offset    (r_addr[1:0]),
    .i_word      (i_cacheData),
    .i_storeData (r_sdata[15:0]),
    .o_loadData  (w_load_ext),
    .o_mergeData (w_merge)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op    <= OpLb;
      r_addr  <= 32'h0;
      r_sdata <= 32'h0;
      r_merge <= 32'h0;
    end else begin
      if (w_accept) begin
        r_op    <= w_op_in;
        r_addr  <= i_address;
        r_sdata <= i_storeData;
      end
      if ((r_state == StRmwRead) && !i_cacheStop) begin
        r_merge <= w_merge;
      end
    end
  end

  always_comb begin
    w_state_next     = r_state;
    o_cacheReadMem   = 1'b0;
    o_cacheWriteMem  = 1'b0;
    o_cacheWriteData = 32'h0;
    o_loadData       = 32'h0;
    o_stall          = 1'b0;
    o_alignErr       = 1'b0;
    // IDLE outputs depend on live inputs, so gate them while reset is held.
    if (i_rst_n) begin
      unique case (r_state)
        StIdle: begin
          if (i_req) begin
            if (w_misaligned) begin
              o_alignErr = 1'b1;
            end else begin
              o_stall      = 1'b1;
              w_state_next = is_rmw(w_op_in) ? StRmwRead : StAccess;
            end
          end
        end
        StAccess: begin
          if (is_load(r_op)) begin
            o_cacheReadMem = 1'b1;
          end else begin
            o_cacheWriteMem  = 1'b1;
            o_cacheWriteData = r_sdata;
          end
          if (i_cacheStop) begin
            o_stall = 1'b1;
          end else begin
            w_state_next = StIdle;
            if (is_load(r_op)) begin
              o_loadData = w_load_ext;
            end
          end
        end
        StRmwRead: begin
          o_cacheReadMem = 1'b1;
          o_stall        = 1'b1;
          if (!i_cacheStop) begin
            w_state_next = StRmwWrite;
          end
        end
        StRmwWrite: begin
          o_cacheWriteMem  = 1'b1;
          o_cacheWriteData = r_merge;
          if (i_cacheStop) begin
            o_stall = 1'b1;
          end else begin
            w_state_next = StIdle;
          end
        end
      endcase
    end
  end

endmodule
